// File: rtl/lcd_pkg.sv
// Shared types and constants for the 4-bit character LCD write path.
// Latency: none (package only).
// Backpressure: none (package only).
package lcd_pkg;

    // Transfer phases, in the order a full byte walks through them
    typedef enum logic [3:0] {
        IDLE,
        HI_SETUP,
        HI_PULSE,
        HI_HOLD,
        GAP,
        LO_SETUP,
        LO_PULSE,
        LO_HOLD,
        WAIT
    } lcd_state_t;

    // Common LCD instruction bytes
    localparam logic [7:0] CLEAR         = 8'h01;
    localparam logic [7:0] HOME          = 8'h02;
    localparam logic [7:0] ENTRY_MODE    = 8'h06;
    localparam logic [7:0] DISPLAY_ON    = 8'h0C;
    localparam logic [7:0] FUNC_SET_4BIT = 8'h28;

    // Default timing for a 50 MHz core clock, in clock cycles
    localparam int T_SETUP_DEF = 2;      // 40 ns
    localparam int T_PULSE_DEF = 12;     // 240 ns
    localparam int T_HOLD_DEF  = 1;      // 20 ns
    localparam int T_GAP_DEF   = 50;     // 1 us
    localparam int T_CMD_DEF   = 2000;   // 40 us
    localparam int T_CLEAR_DEF = 82000;  // 1.64 ms
    localparam int CNT_W_DEF   = 17;

    // Clear/home (0x01..0x03) need the long execution wait, but only as full command bytes
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data, input logic nibble);
        return !rs && !nibble && (data == CLEAR || data == HOME || data == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_nibble_tx_if.sv
// Request/response handshake between the LCD sequencer and the nibble transmitter.
// Latency: none (signal bundle only).
// Backpressure: in_ready low while a transfer is in flight; requester holds in_valid.
interface lcd_nibble_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_rs;
    logic [7:0] in_data;
    logic       in_nibble;
    logic       done;
    logic       busy;

    // Sequencer side
    modport master (
        output in_valid, in_rs, in_data, in_nibble,
        input  in_ready, done, busy
    );

    // Transmitter side
    modport slave (
        input  in_valid, in_rs, in_data, in_nibble,
        output in_ready, done, busy
    );
endinterface

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter: a load of N makes expire pulse in the Nth cycle after the load edge.
// Latency: expire is combinational from the count register.
// Backpressure: none; load always wins over counting.
module lcd_delay_cnt #(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] count;
    logic             running;

    // Count down from load_val-1; stop after the zero cycle so expire fires once
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            running <= 1'b0;
        end else if (load) begin
            count   <= load_val - CNT_W'(1);
            running <= 1'b1;
        end else if (running) begin
            if (count == '0) begin
                running <= 1'b0;
            end else begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign expire = running && (count == '0);

endmodule

// File: rtl/lcd_nibble_tx.sv
// Character-LCD 4-bit write transmitter: byte or single nibble with setup/pulse/hold/gap/exec timing.
// Latency: accept to done = 2*(T_SETUP+T_PULSE+T_HOLD)+T_GAP+wait (byte) or T_SETUP+T_PULSE+T_HOLD+T_CMD (nibble).
// Backpressure: in_ready drops for the whole transfer; requests while busy are ignored, not queued.
module lcd_nibble_tx
    import lcd_pkg::*;
#(
    // Every timing value must be at least 1
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_PULSE = T_PULSE_DEF,
    parameter int T_HOLD  = T_HOLD_DEF,
    parameter int T_GAP   = T_GAP_DEF,
    parameter int T_CMD   = T_CMD_DEF,
    parameter int T_CLEAR = T_CLEAR_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    lcd_nibble_tx_if.slave    req,
    output logic              LCD_E,
    output logic              LCD_RS,
    output logic              LCD_W,
    output logic [3:0]        LCD_DB
);

    localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(T_SETUP);
    localparam logic [CNT_W-1:0] L_PULSE = CNT_W'(T_PULSE);
    localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(T_HOLD);
    localparam logic [CNT_W-1:0] L_GAP   = CNT_W'(T_GAP);
    localparam logic [CNT_W-1:0] L_CMD   = CNT_W'(T_CMD);
    localparam logic [CNT_W-1:0] L_CLEAR = CNT_W'(T_CLEAR);

    lcd_state_t       state;
    logic [3:0]       lo_q;        // low nibble, sent after the gap
    logic             nibble_q;    // single-nibble transfer
    logic             clear_q;     // long execution wait selected
    logic             in_ready_q;
    logic             busy_q;
    logic             done_q;

    logic             accept;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_expire;

    assign accept       = req.in_valid && in_ready_q;
    assign req.in_ready = in_ready_q;
    assign req.busy     = busy_q;
    assign req.done     = done_q;
    assign LCD_W        = 1'b0;

    // Reload the delay counter on every state change with the duration of the state being entered
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state)
            IDLE: begin
                cnt_load = accept;
                cnt_val  = L_SETUP;
            end
            HI_SETUP: begin
                cnt_load = cnt_expire;
                cnt_val  = L_PULSE;
            end
            HI_PULSE: begin
                cnt_load = cnt_expire;
                cnt_val  = L_HOLD;
            end
            HI_HOLD: begin
                cnt_load = cnt_expire;
                cnt_val  = nibble_q ? L_CMD : L_GAP;
            end
            GAP: begin
                cnt_load = cnt_expire;
                cnt_val  = L_SETUP;
            end
            LO_SETUP: begin
                cnt_load = cnt_expire;
                cnt_val  = L_PULSE;
            end
            LO_PULSE: begin
                cnt_load = cnt_expire;
                cnt_val  = L_HOLD;
            end
            LO_HOLD: begin
                cnt_load = cnt_expire;
                cnt_val  = clear_q ? L_CLEAR : L_CMD;
            end
            default: begin
                cnt_load = 1'b0;
                cnt_val  = '0;
            end
        endcase
    end

    lcd_delay_cnt #(
        .CNT_W (CNT_W)
    ) u_delay (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .expire   (cnt_expire)
    );

    // Transfer sequencer with registered LCD pins and handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lo_q       <= 4'h0;
            nibble_q   <= 1'b0;
            clear_q    <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            LCD_E      <= 1'b0;
            LCD_RS     <= 1'b0;
            LCD_DB     <= 4'h0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lo_q       <= req.in_data[3:0];
                        nibble_q   <= req.in_nibble;
                        clear_q    <= is_long_cmd(req.in_rs, req.in_data, req.in_nibble);
                        LCD_RS     <= req.in_rs;
                        LCD_DB     <= req.in_data[7:4];
                        LCD_E      <= 1'b0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= HI_SETUP;
                    end
                end
                HI_SETUP: begin
                    if (cnt_expire) begin
                        LCD_E <= 1'b1;
                        state <= HI_PULSE;
                    end
                end
                HI_PULSE: begin
                    if (cnt_expire) begin
                        LCD_E <= 1'b0;
                        state <= HI_HOLD;
                    end
                end
                HI_HOLD: begin
                    if (cnt_expire) begin
                        state <= nibble_q ? WAIT : GAP;
                    end
                end
                GAP: begin
                    if (cnt_expire) begin
                        LCD_DB <= lo_q;
                        state  <= LO_SETUP;
                    end
                end
                LO_SETUP: begin
                    if (cnt_expire) begin
                        LCD_E <= 1'b1;
                        state <= LO_PULSE;
                    end
                end
                LO_PULSE: begin
                    if (cnt_expire) begin
                        LCD_E <= 1'b0;
                        state <= LO_HOLD;
                    end
                end
                LO_HOLD: begin
                    if (cnt_expire) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_expire) begin
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        in_ready_q <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    LCD_E <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_nibble_tx.sv
// Scoreboard bench for lcd_nibble_tx: expected strobes and done cycles are queued at issue time.
// Latency: checks done cycle against hand-computed accept-to-done counts.
// Backpressure: requests wait on in_ready with a bounded cycle budget.
module tb_lcd_nibble_tx;
    import lcd_pkg::*;

    localparam int TS = 2, TP = 3, TH = 1, TG = 4, TC = 10, TCL = 20, TCL2 = 40;
    localparam int HI_OFF = TS;                       // accept edge to high-nibble E rise
    localparam int LO_OFF = TS + TP + TH + TG + TS;   // accept edge to low-nibble E rise

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_nibble_tx_if bus ();
    lcd_nibble_tx_if bus2 ();

    logic       e, rs_o, w_o;
    logic [3:0] db;
    logic       e2, rs2, w2;
    logic [3:0] db2;

    lcd_nibble_tx #(
        .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_GAP(TG),
        .T_CMD(TC), .T_CLEAR(TCL), .CNT_W(17)
    ) dut (
        .clk(clk), .rst(rst), .req(bus),
        .LCD_E(e), .LCD_RS(rs_o), .LCD_W(w_o), .LCD_DB(db)
    );

    lcd_nibble_tx #(
        .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_GAP(TG),
        .T_CMD(TC), .T_CLEAR(TCL2), .CNT_W(17)
    ) dut2 (
        .clk(clk), .rst(rst), .req(bus2),
        .LCD_E(e2), .LCD_RS(rs2), .LCD_W(w2), .LCD_DB(db2)
    );

    typedef struct {
        int         rise;
        logic       rs;
        logic [3:0] db;
    } strobe_t;

    strobe_t sq[$];
    int      dq[$];
    int      dq2[$];

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;
    bit abort_pulse = 1'b0;
    int rise_cyc = 0;
    logic e_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: got event, expected none (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops expectations whenever the DUTs present a strobe or done
    always @(negedge clk) begin
        check("lcd_w", int'(w_o), 0);
        check("lcd_w2", int'(w2), 0);
        if (e && !e_prev) begin
            rise_cyc = cyc;
            if (sq.size() == 0) begin
                unexpected("unexpected_strobe");
            end else begin
                strobe_t s;
                s = sq.pop_front();
                check("strobe_rise_cycle", cyc, s.rise);
                check("strobe_rs", int'(rs_o), int'(s.rs));
                check("strobe_db", int'(db), int'(s.db));
            end
        end
        if (!e && e_prev) begin
            if (abort_pulse) abort_pulse = 1'b0;
            else check("pulse_width", cyc - rise_cyc, TP);
        end
        e_prev = e;
        if (bus.done) begin
            if (dq.size() == 0) begin
                unexpected("unexpected_done");
            end else begin
                check("done_cycle", cyc, dq.pop_front());
                check("busy_at_done", int'(bus.busy), 0);
                check("ready_at_done", int'(bus.in_ready), 1);
            end
        end
        if (bus2.done) begin
            if (dq2.size() == 0) unexpected("unexpected_done2");
            else check("done2_cycle", cyc, dq2.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on dut; lat is the hand-computed accept-to-done cycle count
    task automatic send(input logic rs, input logic [7:0] d, input logic nib,
                        input int lat, input bit keep_valid, output int acc);
        int n;
        bus.in_rs     = rs;
        bus.in_data   = d;
        bus.in_nibble = nib;
        bus.in_valid  = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 300) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            unexpected("accept_timeout");
            acc = -1;
            bus.in_valid = 1'b0;
        end else begin
            acc = cyc + 1;
            sq.push_back('{acc + HI_OFF, rs, d[7:4]});
            if (!nib) sq.push_back('{acc + LO_OFF, rs, d[3:0]});
            dq.push_back(acc + lat);
            tick();
            bus.in_valid = keep_valid;
            check("busy_after_accept", int'(bus.busy), 1);
            check("ready_after_accept", int'(bus.in_ready), 0);
        end
    endtask

    task automatic send2(input logic [7:0] d, input int lat);
        int n;
        bus2.in_rs     = 1'b0;
        bus2.in_data   = d;
        bus2.in_nibble = 1'b0;
        bus2.in_valid  = 1'b1;
        n = 0;
        while (!bus2.in_ready && n < 300) begin
            tick();
            n++;
        end
        if (!bus2.in_ready) begin
            unexpected("accept2_timeout");
        end else begin
            dq2.push_back(cyc + 1 + lat);
            tick();
        end
        bus2.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((dq.size() != 0 || dq2.size() != 0) && n < 500) begin
            tick();
            n++;
        end
        if (dq.size() != 0 || dq2.size() != 0) unexpected("drain_timeout");
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, n;
        bus.in_valid = 1'b0;  bus.in_rs = 1'b0;  bus.in_data = 8'h00;  bus.in_nibble = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_rs = 1'b0; bus2.in_data = 8'h00; bus2.in_nibble = 1'b0;

        // 1: reset values, then quiet idle
        rst = 1'b1;
        repeat (3) tick();
        check("rst_e", int'(e), 0);
        check("rst_db", int'(db), 0);
        check("rst_rs", int'(rs_o), 0);
        check("rst_ready", int'(bus.in_ready), 1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_state", int'(dut.state), int'(IDLE));
        rst = 1'b0;
        repeat (20) tick();
        check("idle_ready", int'(bus.in_ready), 1);
        check("idle_e", int'(e), 0);

        // 2: data byte 0x41: 2*(2+3+1)+4+10 = 26
        send(1'b1, 8'h41, 1'b0, 26, 1'b0, a1);
        drain();

        // 3: clear vs function-set on the long-clear instance: 12+4+40 = 56, 12+4+10 = 26
        send2(CLEAR, 56);
        drain();
        send2(FUNC_SET_4BIT, 26);
        drain();
        // clear on the default instance (12+4+20), home as nibble stays short, 0x03 as data is short
        send(1'b0, CLEAR, 1'b0, 36, 1'b0, a1);
        drain();
        send(1'b0, HOME, 1'b1, 16, 1'b0, a1);
        drain();
        send(1'b1, 8'h03, 1'b0, 26, 1'b0, a1);
        drain();

        // 4: init nibble 0x3: 2+3+1+10 = 16, single strobe
        send(1'b0, 8'h30, 1'b1, 16, 1'b0, a1);
        drain();

        // 5: in_valid held across back-to-back bytes; second accept in the done cycle of the first
        send(1'b1, 8'h48, 1'b0, 26, 1'b1, a1);
        bus.in_data = 8'h69;
        send(1'b1, 8'h69, 1'b0, 26, 1'b0, a2);
        check("back_to_back_accept", a2, a1 + 27);
        repeat (4) tick();
        bus.in_rs = 1'b0;
        bus.in_data = 8'h55;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("busy_while_ignored", int'(bus.busy), 1);
        drain();

        // 6: reset during the high-nibble pulse abandons the transfer silently
        send(1'b1, 8'h4A, 1'b0, 26, 1'b0, a1);
        n = 0;
        while (!e && n < 50) begin
            tick();
            n++;
        end
        check("pulse_seen_before_reset", int'(e), 1);
        tick();
        rst = 1'b1;
        abort_pulse = 1'b1;
        sq.delete();
        dq.delete();
        tick();
        check("mid_rst_e", int'(e), 0);
        check("mid_rst_state", int'(dut.state), int'(IDLE));
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_ready", int'(bus.in_ready), 1);
        rst = 1'b0;
        repeat (40) tick();
        send(1'b0, DISPLAY_ON, 1'b0, 26, 1'b0, a1);
        drain();

        check("strobe_queue_empty", sq.size(), 0);
        check("done_queue_empty", dq.size(), 0);
        check("done2_queue_empty", dq2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
